sap_cpu_core: RTL and testbench

//  Parametrised SAP-style accumulator CPU core: PC, MAR, IR, A, B, ALU, flags, output reg, register-file RAM, microsequencer.

---
 rtl/sap_cpu_core.sv | 229 ++++++++++++++++++++++
 tb/tb_sap_cpu_core.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_cpu_core.sv
// sap_cpu_core -- parametrised SAP-style accumulator CPU core.
//
// A multi-cycle accumulator machine. It has a program counter, a memory
// address register, an instruction register, the A and B registers, an
// adder/subtractor ALU, carry and zero flags, an output register and a small
// register-file RAM. A microsequencer steps through IDLE, T0..T3 and HALT.
// The program is written into RAM through a valid/ready handshake while the
// core is idle.
//
// Parameters
//   DATA_W  data / instruction width; opcode = instr[DATA_W-1 -: 4]
//   ADDR_W  address width; RAM depth = 2**ADDR_W; operand = instr[ADDR_W-1:0]
//           (DATA_W must be at least ADDR_W+4)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset (also clears the RAM)
//   run         1 = execute, 0 = stop after the current instruction / load mode
//   prog_valid  program write request (accepted only while prog_ready=1)
//   prog_ready  high only in IDLE
//   prog_addr   RAM write address
//   prog_data   RAM write data
//   out_data    output register (written by OUT)
//   out_valid   one-cycle pulse in the cycle after out_data is written
//   halted      high while in HALT
//   cf, zf      carry (SUB: 1 = no borrow) and zero flags, set by ADD/SUB
//
// Optional build macro SAP_CPU_CORE_STEP_EN adds the step_mode and step
// inputs. When step_mode=1, the core holds in T0 until step is seen high.
// It then executes exactly one instruction. When the macro is not defined,
// the core always free-runs with the same timing as step_mode=0.

module sap_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef SAP_CPU_CORE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              cf,
  output logic              zf
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  generate
    if (DATA_W < ADDR_W + 4) begin : g_width_check
      $error("sap_cpu_core: DATA_W must be at least ADDR_W+4");
    end
  endgenerate

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] ram [DEPTH];

  logic [DATA_W-1:0] mem_rd;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              is_mem_op;
  logic              t0_go;
  logic [2:0]        end_state;
  logic [DATA_W-1:0] b_operand;
  logic [DATA_W:0]   alu_res;

  // Adder/subtractor with carry-out in the top bit. Subtraction is A + ~B + 1.
  // This means carry=1 signals "no borrow".
  function automatic logic [DATA_W:0] alu_addsub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y,
                                                 input logic              sub);
    logic [DATA_W-1:0] y_eff;
    y_eff = sub ? ~y : y;
    return {1'b0, x} + {1'b0, y_eff} + {{DATA_W{1'b0}}, sub};
  endfunction

  // Returns the operand field padded with zeros to a full data word.
  function automatic logic [DATA_W-1:0] zext_operand(input logic [ADDR_W-1:0] v);
    return {{(DATA_W-ADDR_W){1'b0}}, v};
  endfunction

  assign mem_rd    = ram[mar];
  assign opcode    = ir[DATA_W-1 -: 4];
  assign operand   = ir[ADDR_W-1:0];
  assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                     (opcode == OP_SUB) || (opcode == OP_STA);

  // When run is low at the end of an instruction, the core returns to IDLE
  // instead of fetching the next instruction.
  assign end_state = run ? S_T0 : S_IDLE;

`ifdef SAP_CPU_CORE_STEP_EN
  assign t0_go = !step_mode || step;
`else
  assign t0_go = 1'b1;
`endif

  // B is latched on the same edge on which the ALU result is committed.
  // During T3 the ALU therefore takes the RAM word directly, so A+B uses the
  // new B value.
  assign b_operand = (state == S_T3) ? mem_rd : b_reg;
  assign alu_res   = alu_addsub(a_reg, b_operand, opcode == OP_SUB);

  assign prog_ready = (state == S_IDLE);
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        // IDLE: program load port is open; run starts execution at address 0
        S_IDLE: begin
          if (run) begin
            state <= S_T0;
            pc    <= '0;
          end else if (prog_valid) begin
            ram[prog_addr] <= prog_data;
          end
        end

        // T0: address phase of fetch
        S_T0: begin
          mar <= pc;
          if (t0_go)    state <= S_T1;
          else if (!run) state <= S_IDLE;
        end

        // T1: instruction fetch, PC advances (wraps naturally at 2**ADDR_W)
        S_T1: begin
          ir    <= mem_rd;
          pc    <= pc + ADDR_W'(1);
          state <= S_T2;
        end

        // T2: decode; register-only instructions complete here
        S_T2: begin
          if (is_mem_op) begin
            mar   <= operand;
            state <= S_T3;
          end else begin
            state <= (opcode == OP_HLT) ? S_HALT : end_state;
            case (opcode)
              OP_LDI: a_reg <= zext_operand(operand);
              OP_JMP: pc    <= operand;
              OP_JC:  if (cf) pc <= operand;
              OP_JZ:  if (zf) pc <= operand;
              OP_OUT: begin
                out_data  <= a_reg;
                out_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end

        // T3: memory-operand execute
        S_T3: begin
          state <= end_state;
          case (opcode)
            OP_LDA: a_reg <= mem_rd;
            OP_ADD, OP_SUB: begin
              b_reg <= mem_rd;
              a_reg <= alu_res[DATA_W-1:0];
              cf    <= alu_res[DATA_W];
              zf    <= (alu_res[DATA_W-1:0] == '0);
            end
            OP_STA: ram[mar] <= a_reg;
            default: ;
          endcase
        end

        // HALT: wait for run to drop, then rewind to address 0
        S_HALT: begin
          if (!run) begin
            state <= S_IDLE;
            pc    <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_cpu_core.sv
// tb_sap_cpu_core -- self-checking bench for sap_cpu_core (DATA_W=8, ADDR_W=4).
// An instruction-level reference model predicts OUT events (cycle and value),
// the halt point and the final flags for random and directed programs.

module tb_sap_cpu_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              prog_valid;
  logic              prog_ready;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic              cf;
  logic              zf;
`ifdef SAP_CPU_CORE_STEP_EN
  logic              step_mode;
  logic              step;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sap_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
`ifdef SAP_CPU_CORE_STEP_EN
    .step_mode  (step_mode),
    .step       (step),
`endif
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted),
    .cf         (cf),
    .zf         (zf)
  );

  logic [7:0] prog [DEPTH];

  int         dut_cyc[$];
  logic [7:0] dut_val[$];
  logic       dut_halted_end;
  logic       dut_idle_ok;
  logic       dut_ready_seen;

  int         exp_cyc[$];
  logic [7:0] exp_val[$];
  logic       m_halted;
  int         m_halt_cyc;
  logic       m_cf, m_zf;
  logic [7:0] m_out;

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef SAP_CPU_CORE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prog_valid = 1'b1;
      prog_addr  = 4'(i);
      prog_data  = prog[i];
    end
    @(negedge clk);
    prog_valid = 1'b0;
  endtask

  // Runs for w cycles counted from the first T0 and records out_valid events.
  // It then drops run and waits, with a bound, for the core to reach IDLE.
  task automatic run_window(input int w, input logic pv, input logic [3:0] pa,
                            input logic [7:0] pd);
    dut_cyc.delete(); dut_val.delete();
    dut_ready_seen = 1'b0;
    dut_halted_end = 1'b0;
    @(negedge clk);
    run = 1'b1;
    if (pv) begin
      prog_valid = 1'b1; prog_addr = pa; prog_data = pd;
    end
    @(posedge clk);
    for (int c = 0; c < w; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        dut_cyc.push_back(c);
        dut_val.push_back(out_data);
      end
      if (prog_ready === 1'b1) dut_ready_seen = 1'b1;
      dut_halted_end = halted;
      @(posedge clk);
    end
    #1;
    run = 1'b0;
    prog_valid = 1'b0;
    dut_idle_ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (prog_ready === 1'b1) begin
        dut_idle_ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  task automatic model_run(input int w);
    logic [7:0] mem [DEPTH];
    logic [7:0] acc, ir;
    int pc, t, op, opnd, len, sum;
    for (int i = 0; i < DEPTH; i++) mem[i] = prog[i];
    exp_cyc.delete(); exp_val.delete();
    acc = 8'h00; m_cf = 1'b0; m_zf = 1'b0; m_out = 8'h00;
    m_halted = 1'b0; m_halt_cyc = 0;
    pc = 0; t = 0;
    while (t < w && !m_halted) begin
      ir   = mem[pc];
      pc   = (pc + 1) % DEPTH;
      op   = int'(ir[7:4]);
      opnd = int'(ir[3:0]);
      len  = 3;
      case (op)
        1: begin acc = mem[opnd]; len = 4; end
        2: begin
          sum  = int'(acc) + int'(mem[opnd]);
          m_cf = (sum > 255);
          acc  = 8'(sum);
          m_zf = (acc == 8'h00);
          len  = 4;
        end
        3: begin
          m_cf = (acc >= mem[opnd]);
          acc  = acc - mem[opnd];
          m_zf = (acc == 8'h00);
          len  = 4;
        end
        4: begin mem[opnd] = acc; len = 4; end
        5: acc = 8'(opnd);
        6: pc = opnd;
        7: if (m_cf) pc = opnd;
        8: if (m_zf) pc = opnd;
        14: begin
          if (t + 3 < w) begin
            exp_cyc.push_back(t + 3);
            exp_val.push_back(acc);
          end
          m_out = acc;
        end
        15: begin m_halted = 1'b1; m_halt_cyc = t + 3; end
        default: ;
      endcase
      t += len;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (prog_ready !== 1'b1) begin failures++; $display("FAIL reset_prog_ready got=%b exp=1", prog_ready); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (cf !== 1'b0 || zf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", cf, zf); end
  endtask

  task automatic test_add_out();
    do_reset(); clear_prog();
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
    prog[14] = 8'h05; prog[15] = 8'h07;
    load_prog(DEPTH);
    run_window(20, 1'b0, 4'h0, 8'h00);
    checks++;
    if (dut_cyc.size() != 1) begin
      failures++; $display("FAIL add_out_count got=%0d exp=1", dut_cyc.size());
    end else if (dut_cyc[0] != 11 || dut_val[0] !== 8'h0C) begin
      failures++; $display("FAIL add_out_event got=%0d/%h exp=11/0c", dut_cyc[0], dut_val[0]);
    end
    checks++; if (dut_halted_end !== 1'b1) begin failures++; $display("FAIL add_halted got=%b exp=1", dut_halted_end); end
    checks++; if (cf !== 1'b0 || zf !== 1'b0) begin failures++; $display("FAIL add_flags got=%b%b exp=00", cf, zf); end
    checks++; if (out_data !== 8'h0C) begin failures++; $display("FAIL add_out_data got=%h exp=0c", out_data); end
  endtask

  task automatic test_sub_jz();
    do_reset(); clear_prog();
    prog[0] = 8'h53; prog[1] = 8'h4F; prog[2] = 8'h3F; prog[3] = 8'h86;
    prog[4] = 8'hE0; prog[5] = 8'hF0; prog[6] = 8'h51; prog[7] = 8'hE0; prog[8] = 8'hF0;
    load_prog(DEPTH);
    run_window(30, 1'b0, 4'h0, 8'h00);
    checks++;
    if (dut_cyc.size() != 1) begin
      failures++; $display("FAIL sub_jz_count got=%0d exp=1", dut_cyc.size());
    end else if (dut_cyc[0] != 20 || dut_val[0] !== 8'h01) begin
      failures++; $display("FAIL sub_jz_event got=%0d/%h exp=20/01", dut_cyc[0], dut_val[0]);
    end
    checks++; if (cf !== 1'b1 || zf !== 1'b1) begin failures++; $display("FAIL sub_jz_flags got=%b%b exp=11", cf, zf); end
    checks++; if (dut_halted_end !== 1'b1) begin failures++; $display("FAIL sub_jz_halted got=%b exp=1", dut_halted_end); end
  endtask

  task automatic test_carry_jc();
    do_reset(); clear_prog();
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h75; prog[3] = 8'hE0;
    prog[4] = 8'hF0; prog[5] = 8'h59; prog[6] = 8'hE0; prog[7] = 8'hF0;
    prog[14] = 8'hFF; prog[15] = 8'h01;
    load_prog(DEPTH);
    run_window(30, 1'b0, 4'h0, 8'h00);
    checks++;
    if (dut_cyc.size() != 1) begin
      failures++; $display("FAIL jc_count got=%0d exp=1", dut_cyc.size());
    end else if (dut_cyc[0] != 17 || dut_val[0] !== 8'h09) begin
      failures++; $display("FAIL jc_event got=%0d/%h exp=17/09", dut_cyc[0], dut_val[0]);
    end
    checks++; if (cf !== 1'b1 || zf !== 1'b1) begin failures++; $display("FAIL jc_flags got=%b%b exp=11", cf, zf); end
  endtask

  task automatic test_pc_wrap();
    int ecyc[3];
    logic [7:0] eval[3];
    ecyc[0] = 7; ecyc[1] = 56; ecyc[2] = 105;
    eval[0] = 8'h01; eval[1] = 8'h02; eval[2] = 8'h03;
    do_reset(); clear_prog();
    prog[0] = 8'h2F; prog[1] = 8'hE0; prog[15] = 8'h01;
    load_prog(DEPTH);
    run_window(120, 1'b0, 4'h0, 8'h00);
    checks++;
    if (dut_cyc.size() != 3) begin
      failures++; $display("FAIL wrap_count got=%0d exp=3", dut_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_cyc[k] != ecyc[k] || dut_val[k] !== eval[k]) begin
          failures++; $display("FAIL wrap_event%0d got=%0d/%h exp=%0d/%h", k, dut_cyc[k], dut_val[k], ecyc[k], eval[k]);
        end
      end
    end
    checks++; if (dut_idle_ok !== 1'b1) begin failures++; $display("FAIL wrap_stop_idle got=%b exp=1", dut_idle_ok); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL wrap_halted got=%b exp=0", halted); end
  endtask

  task automatic test_reset_mid_sta();
    do_reset(); clear_prog();
    prog[0] = 8'h55; prog[1] = 8'h4F; prog[2] = 8'hF0; prog[14] = 8'h77;
    load_prog(DEPTH);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_data !== 8'h00 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out got=%h/%b exp=00/0", out_data, out_valid); end
    checks++; if (halted !== 1'b0 || cf !== 1'b0 || zf !== 1'b0) begin failures++; $display("FAIL rst_mid_status got=%b%b%b exp=000", halted, cf, zf); end
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    checks++; if (prog_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", prog_ready); end
    clear_prog();
    prog[0] = 8'h1E; prog[1] = 8'hE0; prog[2] = 8'hF0;
    load_prog(3);
    run_window(20, 1'b0, 4'h0, 8'h00);
    checks++;
    if (dut_cyc.size() != 1) begin
      failures++; $display("FAIL rst_ram_count got=%0d exp=1", dut_cyc.size());
    end else if (dut_cyc[0] != 7 || dut_val[0] !== 8'h00) begin
      failures++; $display("FAIL rst_ram_clear got=%0d/%h exp=7/00", dut_cyc[0], dut_val[0]);
    end
  endtask

  task automatic test_prog_while_running();
    do_reset(); clear_prog();
    prog[0] = 8'h1F; prog[1] = 8'hE0; prog[2] = 8'hF0; prog[15] = 8'h3C;
    load_prog(DEPTH);
    run_window(20, 1'b1, 4'hF, 8'h99);
    checks++;
    if (dut_cyc.size() != 1 || dut_val[0] !== 8'h3C) begin
      failures++; $display("FAIL drop_first got=%0d/%h exp=1/3c", dut_cyc.size(), (dut_val.size() > 0) ? dut_val[0] : 8'h00);
    end
    checks++; if (dut_ready_seen !== 1'b0) begin failures++; $display("FAIL ready_while_running got=%b exp=0", dut_ready_seen); end
    run_window(20, 1'b0, 4'h0, 8'h00);
    checks++;
    if (dut_cyc.size() != 1 || dut_val[0] !== 8'h3C) begin
      failures++; $display("FAIL drop_second got=%0d/%h exp=1/3c", dut_cyc.size(), (dut_val.size() > 0) ? dut_val[0] : 8'h00);
    end
  endtask

`ifdef SAP_CPU_CORE_STEP_EN
  task automatic step_and_watch(input logic do_step, output int cnt, output logic [7:0] last);
    cnt = 0; last = 8'h00;
    if (do_step) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin cnt++; last = out_data; end
    end
  endtask

  task automatic test_step();
    int cnt;
    logic [7:0] last;
    do_reset(); clear_prog();
    prog[0] = 8'h2F; prog[1] = 8'hE0; prog[2] = 8'h2F; prog[3] = 8'hE0;
    prog[4] = 8'hF0; prog[15] = 8'h01;
    load_prog(DEPTH);
    @(negedge clk);
    step_mode = 1'b1; run = 1'b1;
    step_and_watch(1'b0, cnt, last);
    checks++; if (cnt != 0) begin failures++; $display("FAIL step_hold got=%0d exp=0", cnt); end
    step_and_watch(1'b1, cnt, last);
    checks++; if (cnt != 0) begin failures++; $display("FAIL step_add got=%0d exp=0", cnt); end
    step_and_watch(1'b1, cnt, last);
    checks++; if (cnt != 1 || last !== 8'h01) begin failures++; $display("FAIL step_out1 got=%0d/%h exp=1/01", cnt, last); end
    step_and_watch(1'b1, cnt, last);
    checks++; if (cnt != 0) begin failures++; $display("FAIL step_add2 got=%0d exp=0", cnt); end
    step_and_watch(1'b1, cnt, last);
    checks++; if (cnt != 1 || last !== 8'h02) begin failures++; $display("FAIL step_out2 got=%0d/%h exp=1/02", cnt, last); end
    @(negedge clk);
    step_mode = 1'b0; run = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) prog[i] = 8'($urandom_range(0, 255));
      load_prog(DEPTH);
      model_run(150);
      run_window(150, 1'b0, 4'h0, 8'h00);
      checks++;
      if (dut_cyc.size() != exp_cyc.size()) begin
        failures++; $display("FAIL rand%0d_out_count got=%0d exp=%0d", n, dut_cyc.size(), exp_cyc.size());
      end else begin
        for (int k = 0; k < exp_cyc.size(); k++) begin
          checks++;
          if (dut_cyc[k] != exp_cyc[k] || dut_val[k] !== exp_val[k]) begin
            failures++; $display("FAIL rand%0d_out%0d got=%0d/%h exp=%0d/%h", n, k, dut_cyc[k], dut_val[k], exp_cyc[k], exp_val[k]);
          end
        end
      end
      checks++;
      if (dut_halted_end !== (m_halted && m_halt_cyc <= 149)) begin
        failures++; $display("FAIL rand%0d_halted got=%b exp=%b", n, dut_halted_end, (m_halted && m_halt_cyc <= 149));
      end
      if (m_halted && m_halt_cyc <= 149) begin
        checks++;
        if (cf !== m_cf || zf !== m_zf || out_data !== m_out) begin
          failures++; $display("FAIL rand%0d_final got=%b%b/%h exp=%b%b/%h", n, cf, zf, out_data, m_cf, m_zf, m_out);
        end
      end
      checks++; if (dut_idle_ok !== 1'b1) begin failures++; $display("FAIL rand%0d_stop_idle got=%b exp=1", n, dut_idle_ok); end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
`ifdef SAP_CPU_CORE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    test_reset();
    test_add_out();
    test_sub_jz();
    test_carry_jc();
    test_pc_wrap();
    test_reset_mid_sta();
    test_prog_while_running();
`ifdef SAP_CPU_CORE_STEP_EN
    test_step();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
